pixel_gen: RTL and testbench

Pixel generator stage for the text-mode VGA pipeline. It sits directly downstream of the VRAM readout address generator. It captures the character byte and attribute byte that VRAM returns during each 8-cycle character cell, and looks up the glyph row in the font ROM. It then serializes 8 pixels per cell, MSB first, as a 4-bit color index for the DAC/palette stage, with optional per-character blink.

---
 rtl/pixel_gen_if.sv | 24 ++
 rtl/pixel_gen.sv | 109 ++++++++++
 tb/tb_pixel_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_gen_if.sv
// Signal bundle between the text-mode timing/VRAM/font side and the pixel generator.
// The master side drives timing, VRAM and font data; the slave (pixel_gen) returns font address and pixels.
interface pixel_gen_if;
  logic        vActive;
  logic        hBeginActive;
  logic        hEndActive;
  logic [3:0]  vCount;
  logic        vSync;
  logic [7:0]  vramData;
  logic [11:0] fontAddr;
  logic [7:0]  fontData;
  logic [3:0]  pixColor;
  logic        pixValid;

  modport master (
    output vActive, hBeginActive, hEndActive, vCount, vSync, vramData, fontData,
    input  fontAddr, pixColor, pixValid
  );

  modport slave (
    input  vActive, hBeginActive, hEndActive, vCount, vSync, vramData, fontData,
    output fontAddr, pixColor, pixValid
  );
endinterface

// File: rtl/pixel_gen.sv
// Text-mode pixel generator: fetches char/attr per 8-cycle cell, looks up the font row,
// and serializes 8 pixels MSB first as a 4-bit color index with optional per-character blink.
module pixel_gen #(
  parameter int BLINK_LOG2 = 5
) (
  input logic clk,
  input logic rst,
  pixel_gen_if.slave pg
);

  logic                active;
  logic [2:0]          count;
  logic [7:0]          charReg;
  logic [7:0]          attrReg;
  logic [7:0]          fontReg;
  logic [7:0]          shiftReg;
  logic [3:0]          fgReg;
  logic [2:0]          bgReg;
  logic                blinkReg;
  logic [2:0]          shiftCnt;
  logic                valid;
  logic [BLINK_LOG2:0] frameCnt;
  logic                vSyncD;

  logic load;
  logic blinkPhase;
  logic fgOn;

  // A cell completing at count 7 loads the shifter, even when the line ends on that cycle.
  assign load       = active && (count == 3'd7);
  assign blinkPhase = frameCnt[BLINK_LOG2];
  assign pg.fontAddr = {charReg, pg.vCount};

  // Stage 0: cell fetch (character, attribute, font row)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      count   <= 3'd0;
      charReg <= 8'd0;
      attrReg <= 8'd0;
      fontReg <= 8'd0;
    end else if (!active) begin
      if (pg.hBeginActive && pg.vActive) begin
        active <= 1'b1;
        count  <= 3'd0;
      end
    end else begin
      if (pg.hEndActive) begin
        active <= 1'b0;
      end else begin
        count <= count + 3'd1;
      end
      case (count)
        3'd2:    charReg <= pg.vramData;
        3'd5:    fontReg <= pg.fontData;
        3'd6:    attrReg <= pg.vramData;
        default: ;
      endcase
    end
  end

  // Stage 1: pixel serializer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shiftReg <= 8'd0;
      fgReg    <= 4'd0;
      bgReg    <= 3'd0;
      blinkReg <= 1'b0;
      shiftCnt <= 3'd0;
      valid    <= 1'b0;
    end else if (load) begin
      shiftReg <= fontReg;
      fgReg    <= attrReg[3:0];
      bgReg    <= attrReg[6:4];
      blinkReg <= attrReg[7];
      shiftCnt <= 3'd0;
      valid    <= 1'b1;
    end else if (valid) begin
      shiftReg <= {shiftReg[6:0], 1'b0};
      shiftCnt <= shiftCnt + 3'd1;
      if (shiftCnt == 3'd7) begin
        valid <= 1'b0;
      end
    end
  end

  // Frame counter advances on each falling edge of the active-low vertical sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vSyncD   <= 1'b0;
      frameCnt <= '0;
    end else begin
      vSyncD <= pg.vSync;
      if (vSyncD && !pg.vSync) begin
        frameCnt <= frameCnt + 1'b1;
      end
    end
  end

  always_comb begin
    fgOn        = shiftReg[7] && !(blinkReg && blinkPhase);
    pg.pixValid = valid;
    pg.pixColor = 4'd0;
    if (valid) begin
      pg.pixColor = fgOn ? fgReg : {1'b0, bgReg};
    end
  end

endmodule

// File: tb/tb_pixel_gen.sv
// Directed bench for pixel_gen: single cell, back-to-back line, end alignment, reset, vActive gating, blink.
module tb_pixel_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_gen_if pg();

  pixel_gen #(.BLINK_LOG2(1)) dut (
    .clk(clk),
    .rst(rst),
    .pg (pg)
  );

  int testCnt = 0;
  int failCnt = 0;

  logic [7:0] fontMem [0:4095];
  logic [7:0] charTab [0:79];
  logic [7:0] attrTab [0:79];
  logic [3:0] obsPix  [0:700];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testCnt++;
    assert (obs === expv) else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] expPix(input int g, input int b, input logic [3:0] vc, input logic ph);
    logic [7:0] f;
    logic [7:0] a;
    f = fontMem[{charTab[g], vc}];
    a = attrTab[g];
    if (f[7-b] && !(a[7] && ph)) return a[3:0];
    return {1'b0, a[6:4]};
  endfunction

  // Start strobe at edge E0, then nCycles driven cycles; cycle c is handled at its negedge.
  task automatic runLine(input string tag, input int nCycles, input int endCycle, input int nCells,
                         input logic [3:0] vc, input logic ph, input logic withEnd, output int validCnt);
    logic [11:0] addrPrev;
    logic        expV;
    logic [3:0]  expC;
    int          expCnt;
    int          g;
    int          phs;
    validCnt = 0;
    expCnt   = 0;
    @(negedge clk);
    addrPrev        = pg.fontAddr;
    pg.vCount       = vc;
    pg.vActive      = 1'b1;
    pg.hBeginActive = 1'b1;
    pg.hEndActive   = withEnd;
    for (int c = 1; c <= nCycles; c++) begin
      @(negedge clk);
      pg.hBeginActive = 1'b0;
      pg.fontData     = fontMem[addrPrev];
      addrPrev        = pg.fontAddr;
      expV = (c >= 9) && (c <= 8 * nCells + 8);
      expC = expV ? expPix((c - 9) / 8, (c - 9) % 8, vc, ph) : 4'd0;
      obsPix[c] = pg.pixColor;
      if (expV) expCnt++;
      if (pg.pixValid) validCnt++;
      check({tag, "_valid"}, 32'(pg.pixValid), 32'(expV));
      check({tag, "_color"}, 32'(pg.pixColor), 32'(expC));
      g   = (c - 1) / 8;
      phs = (c - 1) % 8;
      if (phs == 4 && g < nCells)
        check({tag, "_fontAddr"}, 32'(pg.fontAddr), 32'({charTab[g], vc}));
      if (g < 80 && phs == 2)      pg.vramData = charTab[g];
      else if (g < 80 && phs == 6) pg.vramData = attrTab[g];
      else                         pg.vramData = 8'($urandom);
      pg.hEndActive = (c == endCycle);
    end
    pg.hEndActive = 1'b0;
    check({tag, "_count"}, 32'(validCnt), 32'(expCnt));
  endtask

  task automatic idleCheck(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (pg.pixValid || pg.pixColor != 4'd0) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  task automatic vSyncPulse();
    @(negedge clk);
    pg.vSync = 1'b0;
    @(negedge clk);
    pg.vSync = 1'b1;
    @(negedge clk);
  endtask

  logic [3:0] singleExp [0:7];
  int         vcnt;

  initial begin
    rst             = 1'b1;
    pg.vActive      = 1'b0;
    pg.hBeginActive = 1'b0;
    pg.hEndActive   = 1'b0;
    pg.vCount       = 4'd3;
    pg.vSync        = 1'b1;
    pg.vramData     = 8'd0;
    pg.fontData     = 8'd0;
    for (int i = 0; i < 4096; i++) fontMem[i] = 8'(i * 37 + 11);
    fontMem[12'h410] = 8'hA5;
    for (int i = 0; i < 80; i++) begin
      charTab[i] = 8'(i + 8'h20);
      attrTab[i] = 8'((i * 7 + 3) & 8'h7F);
    end
    singleExp = '{4'hE, 4'h1, 4'hE, 4'h1, 4'h1, 4'hE, 4'h1, 4'hE};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(pg.pixValid), 32'd0);
    check("rst_color", 32'(pg.pixColor), 32'd0);
    check("rst_fontAddr", 32'(pg.fontAddr), 32'h003);
    rst = 1'b0;
    idleCheck("idle_after_rst", 5);

    // Single cell: char 41, attr 1E, font A5
    charTab[0] = 8'h41;
    attrTab[0] = 8'h1E;
    runLine("single", 24, 8, 1, 4'd0, 1'b0, 1'b0, vcnt);
    for (int i = 0; i < 8; i++) check("single_hand", 32'(obsPix[9 + i]), 32'(singleExp[i]));
    check("single_after", 32'(obsPix[17]), 32'd0);

    // Begin and end strobes together while idle: start wins
    runLine("beginEnd", 24, 8, 1, 4'd0, 1'b0, 1'b1, vcnt);
    check("beginEnd_first", 32'(obsPix[9]), 32'hE);

    // End strobe while idle is ignored
    @(negedge clk);
    pg.hEndActive = 1'b1;
    @(negedge clk);
    pg.hEndActive = 1'b0;
    idleCheck("endIdle", 12);

    // Full line: 80 back-to-back cells
    for (int i = 0; i < 80; i++) begin
      charTab[i] = 8'(i + 8'h20);
      attrTab[i] = 8'((i * 7 + 3) & 8'h7F);
    end
    runLine("line80", 660, 640, 80, 4'd5, 1'b0, 1'b0, vcnt);
    check("line80_640", 32'(vcnt), 32'd640);

    // End aligned with count 7 of cell 3 (load still happens), then mid-cell end
    runLine("end7", 60, 32, 4, 4'd9, 1'b0, 1'b0, vcnt);
    check("end7_32", 32'(vcnt), 32'd32);
    runLine("end4", 70, 45, 5, 4'd2, 1'b0, 1'b0, vcnt);
    check("end4_40", 32'(vcnt), 32'd40);

    // Start strobe outside the vertical active region
    @(negedge clk);
    pg.vActive      = 1'b0;
    pg.hBeginActive = 1'b1;
    @(negedge clk);
    pg.hBeginActive = 1'b0;
    idleCheck("vInactive", 30);

    // Asynchronous reset in the middle of shifting
    charTab[0] = 8'h41;
    attrTab[0] = 8'h1E;
    runLine("preRst", 12, 0, 1, 4'd0, 1'b0, 1'b0, vcnt);
    check("preRst_on", 32'(pg.pixValid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("asyncRst_valid", 32'(pg.pixValid), 32'd0);
    check("asyncRst_color", 32'(pg.pixColor), 32'd0);
    check("asyncRst_fontAddr", 32'(pg.fontAddr), 32'h000);
    @(negedge clk);
    rst = 1'b0;
    idleCheck("postRst", 30);

    // Blink with attr 9F: phase flips every 2 vSync falls
    attrTab[0] = 8'h9F;
    for (int f = 0; f < 5; f++) begin
      runLine("blink", 20, 8, 1, 4'd0, 1'((f % 4) >= 2), 1'b0, vcnt);
      check("blink_fg", 32'(obsPix[9]), ((f % 4) >= 2) ? 32'h1 : 32'hF);
      check("blink_bg", 32'(obsPix[10]), 32'h1);
      vSyncPulse();
    end

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
